read_resp_streamer: RTL and testbench
=====================================

Name: read_resp_streamer

Overview:
- Sits directly downstream of the read engine. Consumes its RVALID_COPY/RDATA_COPY beats, which have no backpressure.
- Buffers the beats in an internal FIFO and re-emits them as a ready/valid stream with a last-beat marker.
- One transfer of XFER_LENGTH beats at a time.
- Reports free FIFO space so the controller sizes READ_LENGTH to avoid overflow.

Parameters:
- DATA_WIDTH, 64, beat width; matches the read engine data width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy/free-slot width (derived, not overridden).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- XFER_START  in  1  start pulse; sampled only in IDLE
- XFER_LENGTH  in  32  beats expected in this transfer
- BUSY  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
- XFER_DONE  out  1  one-cycle pulse after the last beat is handshaken on the output
- IN_VALID  in  1  beat strobe (from RVALID_COPY)
- IN_DATA  in  DATA_WIDTH  beat data (from RDATA_COPY)
- M_TVALID  out  1  output beat valid
- M_TREADY  in  1  downstream ready
- M_TDATA  out  DATA_WIDTH  output data
- M_TLAST  out  1  high on the final beat of the transfer
- FREE_SLOTS  out  CNT_W  DEPTH minus occupancy, registered
- ERR_OVERFLOW  out  1  sticky: beat arrived with FIFO full and no same-cycle pop
- ERR_UNEXPECTED  out  1  sticky: beat arrived in IDLE, or after XFER_LENGTH beats were received

Behaviour:
- Reset (RST high at a clock edge):
  - FIFO emptied; state IDLE.
  - BUSY=0, XFER_DONE=0, M_TVALID=0, M_TLAST=0, M_TDATA=0.
  - FREE_SLOTS=DEPTH, both error flags=0.
  - Reset mid-transfer discards all buffered data with no DONE pulse.
- States:
  - IDLE: XFER_START=1 latches len=XFER_LENGTH, clears rx_cnt and tx_cnt.
    - len==0 goes to DONE.
    - Otherwise goes to ACTIVE.
  - ACTIVE:
    - rx_cnt increments on each accepted IN_VALID.
    - tx_cnt increments on each M_TVALID&M_TREADY.
    - Goes to DONE on the cycle the beat with tx_cnt==len-1 handshakes.
  - DONE: XFER_DONE=1 and BUSY=1 for exactly one cycle, then IDLE.
  - XFER_START is ignored outside IDLE.
- Input acceptance:
  - IN_VALID is accepted only in ACTIVE with rx_cnt<len and (FIFO not full, or a pop occurs in the same cycle).
  - A beat in IDLE/DONE, or once rx_cnt==len, is dropped and sets ERR_UNEXPECTED.
  - A beat with FIFO full and no pop is dropped and sets ERR_OVERFLOW. rx_cnt does not advance, so the transfer cannot complete; software must reset.
- Latency: a beat written at edge N appears on M_TDATA with M_TVALID=1 after edge N (one-cycle write-to-valid). First-word-fall-through from then on.
- Output handshake:
  - M_TVALID and M_TDATA are held stable until M_TREADY; no valid retraction.
  - M_TLAST = M_TVALID & (tx_cnt==len-1).
- FIFO:
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Pointers are CNT_W bits; full/empty is determined by MSB compare; pointers wrap naturally.
- FREE_SLOTS is updated the cycle after any push/pop.
- Counters are 32-bit unsigned; len up to 2^32-1 is supported, with no wrap inside a transfer.

Optional Feature:
- Macro READ_RESP_STREAMER_STATS_EN.
- When defined, two extra outputs are added:
  - BEAT_TOTAL[31:0]: free-running count of output handshakes; wraps; cleared by RST only.
  - PEAK_OCC[CNT_W-1:0]: maximum occupancy observed since reset.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package read_resp_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE);
  - the length counter width constant (32);
  - a function computing CNT_W from DEPTH.
- Sub-module resp_sync_fifo: a single-clock FWFT FIFO with push/pop/full/empty/count outputs, reused elsewhere.
- The FSM, counters and error logic live in the top level.

Test Plan:
- Start len=4, four back-to-back IN_VALID beats 0xA0..0xA3, M_TREADY=1:
  - M_TDATA A0..A3 on four consecutive cycles;
  - M_TLAST only with A3;
  - XFER_DONE the cycle after, then BUSY=0.
- DEPTH=16, len=16, M_TREADY=0 during 16 beats:
  - FREE_SLOTS reaches 0;
  - no error;
  - releasing ready drains all 16 beats in order, with TLAST on beat 16.
- FIFO full, 17th beat with M_TREADY=0:
  - beat dropped, ERR_OVERFLOW=1 sticky.
- Repeat with M_TREADY=1 on the 17th-beat cycle:
  - accepted, no error, occupancy stays 16.
- Start len=0:
  - XFER_DONE pulse with no M_TVALID.
- IN_VALID while IDLE:
  - ERR_UNEXPECTED=1, FREE_SLOTS stays DEPTH.
- RST asserted with 5 beats buffered mid-transfer:
  - next cycle M_TVALID=0, FREE_SLOTS=DEPTH, BUSY=0, errors cleared, no XFER_DONE.
- With READ_RESP_STREAMER_STATS_EN defined, three transfers of len=3:
  - BEAT_TOTAL=9;
  - PEAK_OCC equals the maximum occupancy induced.

Source files
------------

// File: rtl/read_resp_pkg.sv
// read_resp_pkg: shared state type, length width and FIFO count width helper for the read response streamer
package read_resp_pkg;
  localparam int LEN_W = 32;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/resp_sync_fifo.sv
// resp_sync_fifo: single-clock first-word-fall-through FIFO with MSB-compare full/empty pointers
module resp_sync_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = CW - 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [CW-1:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  // Pointers wrap naturally; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  // Storage needs no reset: empty_o gates every use of the read word
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/read_resp_streamer.sv
// read_resp_streamer: buffers read-engine beats and re-emits one transfer as a ready/valid stream (READ_RESP_STREAMER_STATS_EN adds BEAT_TOTAL/PEAK_OCC)
module read_resp_streamer import read_resp_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  XFER_START,
  input  logic [LEN_W-1:0]      XFER_LENGTH,
  output logic                  BUSY,
  output logic                  XFER_DONE,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TLAST,
  output logic [CNT_W-1:0]      FREE_SLOTS,
  output logic                  ERR_OVERFLOW,
`ifdef READ_RESP_STREAMER_STATS_EN
  output logic                  ERR_UNEXPECTED,
  output logic [31:0]           BEAT_TOTAL,
  output logic [CNT_W-1:0]      PEAK_OCC
`else
  output logic                  ERR_UNEXPECTED
`endif
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, rx_q, rx_d, tx_q, tx_d;
  logic [CNT_W-1:0] free_q, count, occ_d;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic full, empty, push, pop, active, rx_room, last_beat, unexp_q, ovf_q;
  assign active    = state_q == ACTIVE;
  assign pop       = M_TVALID & M_TREADY;
  assign rx_room   = rx_q < len_q;
  assign push      = IN_VALID & active & rx_room & (~full | pop);
  assign last_beat = tx_q == len_q - 1'b1;
  assign occ_d     = count + CNT_W'(push) - CNT_W'(pop);
  assign M_TVALID       = ~empty;
  assign M_TDATA        = empty ? '0 : fifo_data;
  assign M_TLAST        = M_TVALID & last_beat;
  assign BUSY           = state_q != IDLE;
  assign XFER_DONE      = state_q == DONE;
  assign FREE_SLOTS     = free_q;
  assign ERR_OVERFLOW   = ovf_q;
  assign ERR_UNEXPECTED = unexp_q;
  resp_sync_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .CW    (CNT_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .data_i  (IN_DATA),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // Transfer sequencing: start latches the length, the final output handshake ends the transfer
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rx_d    = rx_q + LEN_W'(push);
    tx_d    = tx_q + LEN_W'(pop);
    if (state_q == IDLE && XFER_START) begin
      len_d   = XFER_LENGTH;
      rx_d    = '0;
      tx_d    = '0;
      state_d = XFER_LENGTH == '0 ? DONE : ACTIVE;
    end else if (active && pop && last_beat) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State, counters, registered free-slot count and sticky error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      free_q  <= CNT_W'(DEPTH);
      unexp_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      free_q  <= CNT_W'(DEPTH) - occ_d;
      unexp_q <= unexp_q | (IN_VALID & ~(active & rx_room));
      ovf_q   <= ovf_q | (IN_VALID & active & rx_room & full & ~pop);
    end
  end
`ifdef READ_RESP_STREAMER_STATS_EN
  logic [31:0] beat_q;
  logic [CNT_W-1:0] peak_q;
  assign BEAT_TOTAL = beat_q;
  assign PEAK_OCC   = peak_q;
  // Handshake total wraps freely; peak tracks the post-update occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_q <= '0;
      peak_q <= '0;
    end else begin
      beat_q <= beat_q + 32'(pop);
      if (occ_d > peak_q) peak_q <= occ_d;
    end
  end
`endif
endmodule

// File: tb/tb_read_resp_streamer.sv
// tb_read_resp_streamer: vector table, directed corner sequences and randomized traffic against a queue model
module tb_read_resp_streamer;
  localparam int DW = 64, DEPTH = 16, CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, iv = 1'b0, rdy = 1'b0;
  logic [31:0] len = '0;
  logic [DW-1:0] din = '0;
  logic busy, done, tvalid, tlast, eov, eun;
  logic [DW-1:0] tdata;
  logic [CW-1:0] free;
`ifdef READ_RESP_STREAMER_STATS_EN
  logic [31:0] beat_total;
  logic [CW-1:0] peak_occ;
`endif
  int tests = 0, fails = 0;
  logic [DW-1:0] q[$];
  int mode;
  longint rx_left, tx_left;
  bit m_eov, m_eun;
  typedef struct {
    logic s; logic [31:0] l; logic v; logic [DW-1:0] d; logic r;
    logic busy, done, valid, last; logic [DW-1:0] data; logic [CW-1:0] free;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  read_resp_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .XFER_START(start), .XFER_LENGTH(len),
    .BUSY(busy), .XFER_DONE(done), .IN_VALID(iv), .IN_DATA(din),
    .M_TVALID(tvalid), .M_TREADY(rdy), .M_TDATA(tdata), .M_TLAST(tlast),
    .FREE_SLOTS(free), .ERR_OVERFLOW(eov),
`ifdef READ_RESP_STREAMER_STATS_EN
    .ERR_UNEXPECTED(eun), .BEAT_TOTAL(beat_total), .PEAK_OCC(peak_occ)
`else
    .ERR_UNEXPECTED(eun)
`endif
  );
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic logic [127:0] dut_vec();
    return 128'({busy, done, tvalid, tlast, eov, eun, free, tdata});
  endfunction
  function automatic logic [127:0] model_vec();
    bit v = q.size() > 0;
    logic [DW-1:0] d = v ? q[0] : '0;
    logic [CW-1:0] f = CW'(DEPTH - q.size());
    return 128'({mode != 0, mode == 2, v, v && tx_left == 1, m_eov, m_eun, f, d});
  endfunction
  // Reference behaviour at each rising edge, from the transfer rules in terms of remaining beats
  task automatic model_edge();
    bit pop, push;
    if (rst) begin
      q.delete(); mode = 0; m_eov = 0; m_eun = 0; rx_left = 0; tx_left = 0;
      return;
    end
    pop = q.size() > 0 && rdy;
    push = 0;
    if (iv) begin
      if (mode != 1 || rx_left == 0) m_eun = 1;
      else if (q.size() == DEPTH && !pop) m_eov = 1;
      else push = 1;
    end
    if (pop) begin void'(q.pop_front()); tx_left--; end
    if (push) begin q.push_back(din); rx_left--; end
    if (mode == 2) mode = 0;
    else if (mode == 1 && pop && tx_left == 0) mode = 2;
    else if (mode == 0 && start) begin
      rx_left = len; tx_left = len; mode = (len == 0) ? 2 : 1;
    end
  endtask
  task automatic drive(input logic s, input logic [31:0] l, input logic v, input logic [DW-1:0] d,
                       input logic r, input logic rs = 1'b0);
    @(negedge clk);
    rst = rs; start = s; len = l; iv = v; din = d; rdy = r;
    check("model", dut_vec(), model_vec());
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask
  task automatic cyc(input logic s, input logic [31:0] l, input logic v, input logic [DW-1:0] d,
                     input logic r, input logic rs = 1'b0);
    drive(s, l, v, d, r, rs);
    tick();
  endtask
  initial begin
    mode = 0; rx_left = 0; tx_left = 0; m_eov = 0; m_eun = 0;
    tbl[0] = '{1'b1, 32'd4, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  5'd16};
    tbl[1] = '{1'b0, 32'd0, 1'b1, 64'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  5'd16};
    tbl[2] = '{1'b0, 32'd0, 1'b1, 64'hA1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA0, 5'd15};
    tbl[3] = '{1'b0, 32'd0, 1'b1, 64'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA1, 5'd15};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 64'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA2, 5'd15};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA3, 5'd15};
    tbl[6] = '{1'b0, 32'd0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  5'd16};
    tbl[7] = '{1'b0, 32'd0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  5'd16};
    repeat (2) tick();
    drive(0, 0, 0, 0, 0);
    check("reset_state", 128'({busy, done, tvalid, tlast, eov, eun, free, tdata}), 128'({6'b0, 5'd16, 64'h0}));
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].s, tbl[i].l, tbl[i].v, tbl[i].d, tbl[i].r);
      check("table", 128'({busy, done, tvalid, tlast, tdata, free}),
            128'({tbl[i].busy, tbl[i].done, tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].free}));
      tick();
    end
    cyc(1, 16, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 64'(100 + i), 0);
    drive(0, 0, 0, 0, 0);
    check("fill16_free_noerr", 128'({free, eov, eun}), 128'({5'd0, 2'b00}));
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 1);
      check("drain16", 128'({tvalid, tlast, tdata}), 128'({1'b1, i == 15, 64'(100 + i)}));
      tick();
    end
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 17, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 64'(200 + i), 0);
    cyc(0, 0, 1, 64'd216, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("overflow_sticky", 128'({eov, eun, free, tdata}), 128'({2'b10, 5'd0, 64'd200}));
    tick();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 17, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 64'(300 + i), 0);
    cyc(0, 0, 1, 64'd316, 1);
    drive(0, 0, 0, 0, 0);
    check("full_push_pop", 128'({free, eov, eun}), 128'({5'd0, 2'b00}));
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 1);
      check("drain_after_full", 128'({tlast, tdata}), 128'({i == 15, 64'(301 + i)}));
      tick();
    end
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("len0_done", 128'({busy, done, tvalid}), 128'(3'b110));
    tick();
    drive(0, 0, 0, 0, 1);
    check("len0_idle", 128'({busy, done, tvalid}), 128'(3'b000));
    tick();
    cyc(0, 0, 1, 64'h55, 0);
    drive(0, 0, 0, 0, 0);
    check("idle_beat", 128'({eun, eov, free}), 128'({2'b10, 5'd16}));
    tick();
    cyc(1, 8, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 64'(400 + i), 0);
    cyc(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("mid_reset", 128'({tvalid, free, busy, done, eov, eun}), 128'({1'b0, 5'd16, 4'b0}));
    tick();
    for (int t = 0; t < 40; t++) begin
      int pv = $urandom_range(20, 90);
      int pr = $urandom_range(20, 100);
      cyc(1, $urandom_range(0, 24), 0, 0, 0);
      for (int c = 0; c < 200 && mode != 0; c++)
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 5), $urandom_range(0, 99) < pv,
            {$urandom, $urandom}, $urandom_range(0, 99) < pr);
      if (mode != 0 || $urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0, 1);
      else cyc(0, 0, $urandom_range(0, 1), 64'h77, 1);
    end
`ifdef READ_RESP_STREAMER_STATS_EN
    cyc(0, 0, 0, 0, 0, 1);
    for (int x = 0; x < 3; x++) begin
      cyc(1, 3, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'(500 + i), 0);
      repeat (5) cyc(0, 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0);
    check("stats", 128'({beat_total, peak_occ}), 128'({32'd9, 5'd3}));
    tick();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
